obstacle_scheduler: RTL and testbench

Sequencing controller for the obstacle mux 8-to-1. It picks which of the 8 obstacle generators runs next and drives the mux `select`. It issues a one-cycle start pulse to the chosen generator and waits for that generator's done pulse. It then inserts a fixed idle gap before choosing the next obstacle. It sits between the game-state logic (`game_start`/`game_over`) and the obstacle generators, and its `select` output feeds the mux directly.

---
 rtl/obstacle_scheduler_if.sv | 21 ++
 rtl/obstacle_scheduler.sv | 108 ++++++++++
 tb/tb_obstacle_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_scheduler_if.sv
// Handshake bundle between the game-state/generator side and the obstacle scheduler.
// The master drives game control and done pulses; the scheduler (slave) drives mux select and start pulses.
interface obstacle_scheduler_if;
    logic       game_start;
    logic       game_over;
    logic [7:0] obstacle_done;
    logic [2:0] select;
    logic [7:0] obstacle_start;
    logic       active;
    logic [7:0] obstacle_count;

    modport master (
        output game_start, game_over, obstacle_done,
        input  select, obstacle_start, active, obstacle_count
    );

    modport slave (
        input  game_start, game_over, obstacle_done,
        output select, obstacle_start, active, obstacle_count
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Picks the next of 8 obstacle generators from a free-running LFSR, pulses its start,
// waits for its done, then idles GAP_CYCLES before the next pick.
module obstacle_scheduler #(
    parameter logic [31:0] GAP_CYCLES = 32'd50_000_000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    obstacle_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] gap_r;
    logic [7:0]  lfsr_r;
    logic [2:0]  select_r;
    logic [7:0]  start_r;
    logic        active_r;
    logic [7:0]  count_r;
    logic [2:0]  cand_s;
    logic [2:0]  next_sel_s;
    logic        done_sel_s;

    // Candidate pick; bump by one so the same generator never runs twice in a row.
    always_comb begin
        cand_s     = lfsr_r[2:0];
        next_sel_s = (cand_s == select_r) ? (cand_s + 3'd1) : cand_s;
        done_sel_s = bus.obstacle_done[select_r];
    end

    // Selection LFSR: shifts on every clock regardless of FSM state.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // Scheduling FSM with registered outputs; game_over wins over every other input.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            gap_r    <= 32'd0;
            select_r <= 3'd0;
            start_r  <= 8'd0;
            active_r <= 1'b0;
            count_r  <= 8'd0;
        end else if (bus.game_over) begin
            state_r  <= ST_IDLE;
            start_r  <= 8'd0;
            active_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    start_r  <= 8'd0;
                    active_r <= 1'b0;
                    if (bus.game_start) begin
                        count_r <= 8'd0;
                        gap_r   <= GAP_CYCLES - 32'd1;
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_r == 32'd0) begin
                        select_r <= next_sel_s;
                        start_r  <= 8'd1 << next_sel_s;
                        active_r <= 1'b1;
                        state_r  <= ST_START;
                    end else begin
                        gap_r <= gap_r - 32'd1;
                    end
                end
                ST_START: begin
                    start_r <= 8'd0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (done_sel_s) begin
                        if (count_r != 8'd255) begin
                            count_r <= count_r + 8'd1;
                        end
                        gap_r    <= GAP_CYCLES - 32'd1;
                        active_r <= 1'b0;
                        state_r  <= ST_GAP;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    start_r  <= 8'd0;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.select         = select_r;
    assign bus.obstacle_start = start_r;
    assign bus.active         = active_r;
    assign bus.obstacle_count = count_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: event-timestamp reference model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_obstacle_scheduler;

    localparam int         G    = 4;
    localparam logic [7:0] SEED = 8'h01;

    logic pclk;
    logic rst_n;
    int   checks;
    int   failures;

    obstacle_scheduler_if bus_if ();

    obstacle_scheduler #(.GAP_CYCLES(32'(G)), .LFSR_SEED(SEED)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Reference model: tracks when the next start is due as an edge timestamp.
    logic [7:0] m_lfsr;
    logic [2:0] m_sel;
    logic [2:0] cand;
    logic [7:0] m_start;
    logic       m_active;
    logic [7:0] m_count;
    logic       m_engaged;
    int         m_start_at;
    int         m_run_from;
    int         cyc;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = SEED; m_sel = 3'd0; m_start = 8'd0; m_active = 1'b0; m_count = 8'd0;
            m_engaged = 1'b0; m_start_at = -1; m_run_from = -1; cyc = 0;
        end else begin
            cyc++;
            cand   = m_lfsr[2:0];
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            m_start = 8'd0;
            if (bus_if.game_over) begin
                m_engaged = 1'b0; m_active = 1'b0; m_start_at = -1;
            end else if (!m_engaged) begin
                if (bus_if.game_start) begin
                    m_engaged = 1'b1; m_count = 8'd0; m_start_at = cyc + G;
                end
            end else if (cyc == m_start_at) begin
                m_sel = (cand == m_sel) ? cand + 3'd1 : cand;
                m_start = 8'd1 << m_sel;
                m_active = 1'b1; m_run_from = cyc + 2; m_start_at = -1;
            end else if (m_active && cyc >= m_run_from && bus_if.obstacle_done[m_sel]) begin
                if (m_count != 8'd255) m_count = m_count + 8'd1;
                m_active = 1'b0; m_start_at = cyc + G;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge pclk) begin
        if (rst_n) begin
            checks++;
            if (bus_if.select !== m_sel || bus_if.obstacle_start !== m_start ||
                bus_if.active !== m_active || bus_if.obstacle_count !== m_count) begin
                failures++;
                $display("FAIL model_cmp cyc=%0d actual sel=%0d start=%02h act=%0b cnt=%0d expected sel=%0d start=%02h act=%0b cnt=%0d",
                         cyc, bus_if.select, bus_if.obstacle_start, bus_if.active, bus_if.obstacle_count,
                         m_sel, m_start, m_active, m_count);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (bus_if.obstacle_start == 8'd0 && n < 40) begin
            tick();
            n++;
        end
        check("start_seen", 32'(bus_if.obstacle_start != 8'd0), 32'd1);
    endtask

    // Release reset, pulse game_start, and check the first pick against hand-computed LFSR values.
    task automatic start_from_reset();
        @(negedge pclk);
        rst_n = 1'b1;
        tick();
        bus_if.game_start = 1'b1;
        tick();
        bus_if.game_start = 1'b0;
        repeat (3) tick();
        check("no_early_start", 32'(bus_if.obstacle_start), 32'd0);
        tick();
        check("first_start", 32'(bus_if.obstacle_start), 32'h08);
        check("first_select", 32'(bus_if.select), 32'd3);
        check("first_active", 32'(bus_if.active), 32'd1);
        tick();
        check("start_one_cycle", 32'(bus_if.obstacle_start), 32'd0);
    endtask

    logic [2:0] prev_sel;
    logic [2:0] held_sel;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus_if.game_start = 1'b0;
        bus_if.game_over = 1'b0;
        bus_if.obstacle_done = 8'd0;
        #1;
        check("reset_select", 32'(bus_if.select), 32'd0);
        check("reset_start", 32'(bus_if.obstacle_start), 32'd0);
        check("reset_active", 32'(bus_if.active), 32'd0);
        check("reset_count", 32'(bus_if.obstacle_count), 32'd0);
        repeat (3) @(posedge pclk);

        start_from_reset();

        // Completion of the first obstacle.
        bus_if.obstacle_done = 8'h08;
        tick();
        bus_if.obstacle_done = 8'd0;
        check("count_after_done", 32'(bus_if.obstacle_count), 32'd1);
        check("active_fall", 32'(bus_if.active), 32'd0);
        repeat (3) tick();
        check("gap_no_start", 32'(bus_if.obstacle_start), 32'd0);
        tick();
        check("second_start_timing", 32'(bus_if.obstacle_start != 8'd0), 32'd1);
        check("second_select_differs", 32'(bus_if.select != 3'd3), 32'd1);
        tick();

        // Done on every bit except the selected one is ignored.
        bus_if.obstacle_done = ~(8'd1 << bus_if.select);
        tick();
        bus_if.obstacle_done = 8'd0;
        check("wrong_done_count", 32'(bus_if.obstacle_count), 32'd1);
        check("wrong_done_active", 32'(bus_if.active), 32'd1);
        repeat (6) tick();
        check("wrong_done_no_start", 32'(bus_if.obstacle_start), 32'd0);

        // Complete it, then pulse done during the START cycle of the next obstacle.
        bus_if.obstacle_done = 8'd1 << bus_if.select;
        tick();
        bus_if.obstacle_done = 8'd0;
        wait_start();
        bus_if.obstacle_done = 8'd1 << bus_if.select;
        tick();
        bus_if.obstacle_done = 8'd0;
        check("start_done_ignored_count", 32'(bus_if.obstacle_count), 32'd2);
        check("start_done_ignored_active", 32'(bus_if.active), 32'd1);

        // game_over beats obstacle_done in the same cycle.
        held_sel = bus_if.select;
        bus_if.game_over = 1'b1;
        bus_if.obstacle_done = 8'd1 << bus_if.select;
        tick();
        bus_if.game_over = 1'b0;
        bus_if.obstacle_done = 8'd0;
        check("over_count_held", 32'(bus_if.obstacle_count), 32'd2);
        check("over_active", 32'(bus_if.active), 32'd0);
        check("over_select_held", 32'(bus_if.select), 32'(held_sel));
        for (int i = 0; i < G + 3; i++) begin
            tick();
            check("over_no_start", 32'(bus_if.obstacle_start), 32'd0);
        end
        bus_if.game_start = 1'b1;
        tick();
        bus_if.game_start = 1'b0;
        check("restart_count_clear", 32'(bus_if.obstacle_count), 32'd0);

        // Long run: saturation, no repeats, one-hot start matching select.
        prev_sel = bus_if.select;
        for (int n = 0; n < 300; n++) begin
            wait_start();
            check("consec_distinct", 32'(bus_if.select != prev_sel), 32'd1);
            check("start_matches_select", 32'(bus_if.obstacle_start), 32'(8'd1 << bus_if.select));
            prev_sel = bus_if.select;
            tick();
            bus_if.obstacle_done = 8'd1 << bus_if.select;
            tick();
            bus_if.obstacle_done = 8'd0;
        end
        check("count_saturated", 32'(bus_if.obstacle_count), 32'd255);

        // Asynchronous reset between edges while in RUN.
        wait_start();
        tick();
        tick();
        check("pre_reset_active", 32'(bus_if.active), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_select", 32'(bus_if.select), 32'd0);
        check("async_start", 32'(bus_if.obstacle_start), 32'd0);
        check("async_active", 32'(bus_if.active), 32'd0);
        check("async_count", 32'(bus_if.obstacle_count), 32'd0);
        start_from_reset();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
